// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// Holds the FSM state encoding and the index-width function.
package ram_arb_pkg;

  typedef enum logic {
    CLEAR,
    SERVE
  } arb_state_t;

  localparam int MAX_REQ = 8;

  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant and an internal priority pointer.
// The pointer moves past the winner only when the grant is accepted.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = req_idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic          i_accept,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (i_en && !found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (i_en && i_accept && found) begin
      ptr <= IW'((int'(o_grant_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters with round-robin
// arbitration; zero-fills the whole RAM after reset or on i_clear.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int NUM_REQ        = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_clear,
  output logic                               o_busy,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ-1:0]                 i_req_we,
  input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0]  i_req_wr_data,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic [NUM_REQ-1:0]                 o_rsp_valid,
  output logic [RAM_DATA_WIDTH-1:0]          o_rsp_rd_data,
  output logic                               o_ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]          o_ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]          o_ram_wr_data,
  input  logic [RAM_DATA_WIDTH-1:0]          i_ram_rd_data
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int DW = RAM_DATA_WIDTH;
  localparam int IW = req_idx_w(NUM_REQ);
  localparam logic [AW-1:0] LAST = '1;

  arb_state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               granted;

  // i_clear blocks arbitration in its own cycle so no access races the fill
  assign arb_en  = (state == SERVE) && !i_clear && !rst;
  assign granted = |grant;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req_valid),
    .i_en        (arb_en),
    .i_accept    (1'b1),
    .o_grant     (grant),
    .o_grant_idx (gidx)
  );

  assign o_req_ready = grant;
  assign o_busy      = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = SERVE;
          cnt_nxt   = '0;
        end
      end
      SERVE: begin
        if (i_clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    o_ram_we      = 1'b0;
    o_ram_addr    = '0;
    o_ram_wr_data = '0;
    if (state == CLEAR) begin
      o_ram_we   = !rst;
      o_ram_addr = cnt;
    end else if (granted) begin
      o_ram_we      = i_req_we[gidx];
      o_ram_addr    = i_req_addr[gidx*AW +: AW];
      o_ram_wr_data = i_req_wr_data[gidx*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rsp_valid   <= '0;
      o_rsp_rd_data <= '0;
    end else begin
      o_rsp_valid <= '0;
      if (granted && !i_req_we[gidx]) begin
        o_rsp_valid   <= grant;
        o_rsp_rd_data <= i_ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural external RAM.
// Hand-computed expectations checked with immediate assertions.
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_clear;
  logic            o_busy;
  logic [N-1:0]    valid;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_rsp_valid;
  logic [DW-1:0]   o_rsp_rd_data;
  logic            o_ram_we;
  logic [AW-1:0]   o_ram_addr;
  logic [DW-1:0]   o_ram_wr_data;
  logic [DW-1:0]   ram_rd;
  logic            seed;

  logic [DW-1:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .RAM_ADDR_WIDTH (AW),
    .RAM_DATA_WIDTH (DW),
    .NUM_REQ        (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (i_clear),
    .o_busy        (o_busy),
    .i_req_valid   (valid),
    .i_req_we      (we),
    .i_req_addr    (addr),
    .i_req_wr_data (wdata),
    .o_req_ready   (o_req_ready),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_rd_data (o_rsp_rd_data),
    .o_ram_we      (o_ram_we),
    .o_ram_addr    (o_ram_addr),
    .o_ram_wr_data (o_ram_wr_data),
    .i_ram_rd_data (ram_rd)
  );

  assign ram_rd = mem[o_ram_addr];

  // garbage seed so a missing zero-fill is visible
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (o_ram_we) begin
      mem[o_ram_addr] <= o_ram_wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    valid[k]          = v;
    we[k]             = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic check_fill(input string tag);
    for (int i = 0; i < 256; i++) begin
      #1;
      chk(tag, {o_busy, o_ram_we, o_ram_addr, o_ram_wr_data, o_req_ready},
          {1'b1, 1'b1, 8'(i), 32'h0, 2'b00});
      tick();
    end
    #1;
    chk({tag, "_done"}, {63'h0, o_busy}, 64'h0);
  endtask

  initial begin
    valid = '0; we = '0; addr = '0; wdata = '0;
    i_clear = 1'b0; rst = 1'b1; seed = 1'b1;
    tick();
    seed = 1'b0;
    #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_ram_we", o_ram_we, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_data", o_rsp_rd_data, 0);
    chk("rst_busy", o_busy, 1);
    tick();
    rst = 1'b0;
    check_fill("reset_fill");

    // read of a cleared location
    set_req(0, 1, 0, 8'h5A, 0);
    #1;
    chk("rd5a_ready", o_req_ready, 2'b01);
    chk("rd5a_addr", {o_ram_we, o_ram_addr}, {1'b0, 8'h5A});
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("rd5a_rsp_valid", o_rsp_valid, 2'b01);
    chk("rd5a_rsp_data", o_rsp_rd_data, 32'h0);

    // write then read-after-write from the other requester
    set_req(0, 1, 1, 8'h10, 32'hDEADBEEF);
    #1;
    chk("wr10_ready", o_req_ready, 2'b01);
    chk("wr10_ram", {o_ram_we, o_ram_addr, o_ram_wr_data},
        {1'b1, 8'h10, 32'hDEADBEEF});
    tick();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 0, 8'h10, 0);
    #1;
    chk("wr10_no_rsp", o_rsp_valid, 2'b00);
    chk("rd10_ready", o_req_ready, 2'b10);
    tick();
    set_req(1, 0, 0, 0, 0);
    chk("rd10_rsp_valid", o_rsp_valid, 2'b10);
    chk("rd10_rsp_data", o_rsp_rd_data, 32'hDEADBEEF);

    set_req(1, 1, 1, 8'h20, 32'h12345678);
    #1;
    chk("wr20_ready", o_req_ready, 2'b10);
    tick();
    set_req(1, 0, 0, 0, 0);

    // both requesters contend: strict alternation from pointer 0
    set_req(0, 1, 0, 8'h10, 0);
    set_req(1, 1, 0, 8'h20, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready", o_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("rr_rsp_valid", o_rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_rsp_data", o_rsp_rd_data,
          (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);

    // clear collides with a write: the write is dropped
    set_req(0, 1, 1, 8'h30, 32'hCAFEF00D);
    i_clear = 1'b1;
    #1;
    chk("clr_ready", o_req_ready, 2'b00);
    chk("clr_ram_we", o_ram_we, 0);
    tick();
    i_clear = 1'b0;
    set_req(0, 0, 0, 0, 0);
    check_fill("clear_fill");
    set_req(0, 1, 0, 8'h30, 0);
    #1;
    chk("rd30_ready", o_req_ready, 2'b01);
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("rd30_rsp_valid", o_rsp_valid, 2'b01);
    chk("rd30_rsp_data", o_rsp_rd_data, 32'h0);

    // pending read response survives a following clear
    set_req(1, 1, 1, 8'h40, 32'hA1B2C3D4);
    #1;
    chk("wr40_ready", o_req_ready, 2'b10);
    tick();
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 0, 8'h40, 0);
    #1;
    chk("rd40_ready", o_req_ready, 2'b01);
    tick();
    i_clear = 1'b1;
    #1;
    chk("rd40_rsp_valid", o_rsp_valid, 2'b01);
    chk("rd40_rsp_data", o_rsp_rd_data, 32'hA1B2C3D4);
    chk("rd40_clr_ready", o_req_ready, 2'b00);
    chk("rd40_clr_busy", o_busy, 0);
    tick();
    i_clear = 1'b0;
    set_req(0, 0, 0, 0, 0);
    chk("rd40_rsp_gone", o_rsp_valid, 2'b00);
    check_fill("late_clear_fill");

    // reset mid-fill restarts at address 0
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_addr", o_ram_addr, 8'd100);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", o_ram_we, 0);
    tick();
    rst = 1'b0;
    check_fill("restart_fill");

    // pointer returned to 0 by reset
    set_req(0, 1, 0, 8'h40, 0);
    set_req(1, 1, 0, 8'h10, 0);
    #1;
    chk("post_rst_ready", o_req_ready, 2'b01);
    tick();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    chk("post_rst_rsp_valid", o_rsp_valid, 2'b01);
    chk("post_rst_rsp_data", o_rsp_rd_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port RAM (synchronous write, combinational read, one address for both) between NUM_REQ requesters.
- Per-requester valid/ready request channel; read data is returned one cycle after the grant.
- Fair round-robin arbitration.
- On reset, or on request, runs a zero-fill sequence that clears the whole RAM before it serves traffic.

Parameters:
- RAM_ADDR_WIDTH, 8: RAM address width; RAM_DEPTH = 2**RAM_ADDR_WIDTH.
- RAM_DATA_WIDTH, 32: RAM word width.
- NUM_REQ, 2: number of requesters; legal range 2..8.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_clear  in  1  one-cycle pulse; starts a zero-fill.
- o_busy  out  1  high while zero-fill is running.
- i_req_valid  in  NUM_REQ  request valid, one bit per requester.
- i_req_we  in  NUM_REQ  1 = write, 0 = read.
- i_req_addr  in  NUM_REQ*RAM_ADDR_WIDTH  requester k uses bits [k*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH].
- i_req_wr_data  in  NUM_REQ*RAM_DATA_WIDTH  requester k uses bits [k*RAM_DATA_WIDTH +: RAM_DATA_WIDTH].
- o_req_ready  out  NUM_REQ  one-hot grant; at most one bit high.
- o_rsp_valid  out  NUM_REQ  one-cycle read-response strobe per requester.
- o_rsp_rd_data  out  RAM_DATA_WIDTH  read data; shared by all requesters, qualified by o_rsp_valid.
- o_ram_we  out  1  RAM write enable.
- o_ram_addr  out  RAM_ADDR_WIDTH  RAM address.
- o_ram_wr_data  out  RAM_DATA_WIDTH  RAM write data.
- i_ram_rd_data  in  RAM_DATA_WIDTH  RAM combinational read data.

Behaviour:
- Reset and reset values:
  - While rst = 1 (synchronous): state = CLEAR, clear counter = 0, priority pointer = 0, o_rsp_valid = 0, o_rsp_rd_data = 0.
  - While rst = 1, the combinational outputs are forced low: o_req_ready = 0, o_ram_we = 0.
  - o_busy = 1 out of reset.
- States: CLEAR, SERVE.
- CLEAR:
  - Each cycle: o_ram_we = 1, o_ram_addr = counter, o_ram_wr_data = 0, o_req_ready = 0, o_busy = 1.
  - Counter increments every cycle.
  - When counter = RAM_DEPTH-1: move to SERVE next cycle and reset the counter to 0.
  - Takes exactly RAM_DEPTH cycles.
  - i_clear is ignored in CLEAR.
  - rst asserted mid-clear restarts the fill at address 0.
- SERVE, arbitration:
  - o_busy = 0.
  - Grant g = first requester with valid = 1, searching from the priority pointer upward and wrapping modulo NUM_REQ.
  - o_req_ready[g] = 1, combinational from the valid bits and the pointer.
  - Handshake completes when valid and ready are both high in the same cycle.
- SERVE, RAM drive:
  - o_ram_addr / o_ram_we / o_ram_wr_data are muxed combinationally from requester g.
  - With no grant: o_ram_we = 0, o_ram_addr = 0.
- SERVE, fairness:
  - After a grant, pointer <= (g+1) mod NUM_REQ.
  - With no grant, the pointer holds.
  - Continuous requesters are served strictly in turn; no requester waits more than NUM_REQ-1 grants.
- Reads:
  - On a granted read, i_ram_rd_data is registered into o_rsp_rd_data.
  - o_rsp_valid[g] = 1 for exactly the next cycle.
  - o_rsp_rd_data holds its value until the next read response.
  - Back-to-back reads give one response per cycle.
- Writes:
  - RAM updates at the grant edge; no response strobe.
  - A read of the same address granted the next cycle returns the new data.
- Requester rules: valid, we, addr and wr_data must stay stable until ready. The block does not check this.
- i_clear in SERVE:
  - In that cycle all o_req_ready = 0 and no grant is made.
  - State moves to CLEAR next cycle.
  - A response strobe pending from the previous cycle's read is still delivered.
  - Pointer is not changed.
- Simultaneous rst and i_clear: rst wins, giving a normal reset-initiated clear.

Decomposition:
- Package ram_arb_pkg holds:
  - enum arb_state_t {CLEAR, SERVE};
  - localparam MAX_REQ = 8;
  - the index-width function clog2-based req_idx_w.
- Sub-module rr_arbiter (parameter N):
  - Inputs: clk, rst, i_req[N], i_en, i_accept.
  - Outputs: o_grant[N] (one-hot), o_grant_idx.
  - Keeps its own priority pointer.
  - Reused by other shared-resource controllers in the codebase.
- Top level holds the FSM, clear counter, RAM mux and response register. It instantiates the RAM externally; it does not embed it.

Test Plan:
- Reset, then wait: o_busy high for exactly 256 cycles with addr 0..255, we = 1, data 0. Then o_busy = 0; a read of addr 0x5A returns 0x00000000 with o_rsp_valid[k] one cycle after the grant.
- Req0 writes 0xDEADBEEF to 0x10; next cycle req1 reads 0x10 -> o_rsp_valid = 2'b10 one cycle later, o_rsp_rd_data = 0xDEADBEEF.
- Both requesters hold valid reads for 6 cycles, pointer = 0 -> grants 0,1,0,1,0,1. Responses alternate with matching data; o_req_ready is never 2'b11.
- i_clear pulse in the same cycle as a req0 valid write -> no ready that cycle, o_busy high next cycle for 256 cycles. The write never occurs; read-back after the clear gives 0.
- Read granted in cycle T, i_clear in cycle T+1 -> o_rsp_valid is still asserted in T+1 with correct data; the clear starts in T+2.
- rst asserted at clear address 100 for 1 cycle -> the fill restarts at address 0 and runs a full 256 cycles.
